// File: rtl/cv32e40p_x_disp_mo.sv
// cv32e40p_x_disp_mo: multi-outstanding CORE-V-XIF dispatcher sitting beside the ID-stage decoder.
// Tracks offloaded instructions by ID, counts pending register writes per register
// and routes result/memory handshakes back to the owning table entry.
// Optional feature macro CV32E40P_X_DISP_KILL_EN: registers commit one cycle after issue,
// adds flush_i and lets a flushed commit kill (free) its entry.
module cv32e40p_x_disp_mo #(
    parameter int ID_WIDTH        = 4,
    parameter int NUM_RS          = 3,
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
`ifdef CV32E40P_X_DISP_KILL_EN
    input  logic                  flush_i,
`endif
    input  logic                  instr_valid_i,
    input  logic                  x_illegal_insn_dec_i,
    input  logic                  branch_or_jump_i,
    input  logic                  id_ready_i,
    input  logic                  ex_ready_i,
    input  logic [4:0]            waddr_id_i,
    input  logic [NUM_RS*5-1:0]   rs_addr_i,
    input  logic [NUM_RS-1:0]     regs_used_i,
    output logic                  x_issue_valid_o,
    input  logic                  x_issue_ready_i,
    input  logic                  x_issue_resp_accept_i,
    input  logic                  x_issue_resp_writeback_i,
    input  logic                  x_issue_resp_loadstore_i,
    output logic [ID_WIDTH-1:0]   x_issue_req_id_o,
    output logic [NUM_RS-1:0]     x_issue_req_rs_valid_o,
    output logic                  x_commit_valid_o,
    output logic [ID_WIDTH-1:0]   x_commit_id_o,
    output logic                  x_commit_kill_o,
    input  logic                  x_result_valid_i,
    output logic                  x_result_ready_o,
    input  logic [ID_WIDTH-1:0]   x_result_id_i,
    input  logic [4:0]            x_result_rd_i,
    input  logic                  x_result_we_i,
    input  logic                  x_mem_valid_i,
    input  logic [ID_WIDTH-1:0]   x_mem_id_i,
    output logic                  x_mem_ready_o,
    output logic                  x_mem_data_req_o,
    output logic                  x_stall_o,
    output logic                  x_illegal_insn_o,
    output logic                  x_prot_err_o,
    output logic [CNT_W-1:0]      x_outstanding_o
);

    logic [MAX_OUTSTANDING-1:0] r_vld, r_we, r_ls;
    logic [ID_WIDTH-1:0]        r_eid [MAX_OUTSTANDING];
    logic [CNT_W-1:0]           r_pend [32];
    logic [ID_WIDTH-1:0]        r_id;
    logic                       r_off;
    logic                       r_prot_err;

    logic                       w_full, w_fire, w_accept, w_alloc, w_inc;
    logic                       w_res_dec, w_res_bad, w_res_ign, w_uflow, w_kill_dec, w_dep;
    logic [CNT_W-1:0]           w_occ;
    logic [MAX_OUTSTANDING-1:0] w_free_oh, w_alloc_oh, w_res_oh, w_res_free, w_mem_oh, w_kill_oh;
    logic [4:0]                 w_kill_rd;
    logic [CNT_W-1:0]           w_pend_n [32];
    logic [CNT_W:0]             w_add, w_sub;
    logic [NUM_RS-1:0]          w_rs_ok;

    // Occupancy, lowest free slot, and first valid entry matching the result / memory IDs
    always_comb begin
        w_occ     = '0;
        w_free_oh = '0;
        w_res_oh  = '0;
        w_mem_oh  = '0;
        for (int e = 0; e < MAX_OUTSTANDING; e++) begin
            w_occ = w_occ + CNT_W'(r_vld[e]);
            if (!r_vld[e] && (w_free_oh == '0))
                w_free_oh[e] = 1'b1;
            if (r_vld[e] && (r_eid[e] == x_result_id_i) && (w_res_oh == '0))
                w_res_oh[e] = 1'b1;
            if (r_vld[e] && r_ls[e] && (r_eid[e] == x_mem_id_i) && (w_mem_oh == '0))
                w_mem_oh[e] = 1'b1;
        end
    end

    assign w_full           = (w_occ == CNT_W'(MAX_OUTSTANDING));
    assign x_issue_valid_o  = instr_valid_i & x_illegal_insn_dec_i & ~branch_or_jump_i & ~r_off & ~w_full;
    assign w_fire           = x_issue_valid_o & x_issue_ready_i;
    assign w_accept         = w_fire & x_issue_resp_accept_i;
    assign w_alloc          = w_accept & (x_issue_resp_writeback_i | x_issue_resp_loadstore_i);
    assign w_alloc_oh       = w_free_oh & {MAX_OUTSTANDING{w_alloc}};
    assign w_inc            = w_accept & x_issue_resp_writeback_i & (waddr_id_i != 5'd0);
    assign x_illegal_insn_o = w_fire & ~x_issue_resp_accept_i;

    assign w_res_free = w_res_oh & {MAX_OUTSTANDING{x_result_valid_i}};
    assign w_res_dec  = (|(w_res_free & r_we)) & x_result_we_i & (x_result_rd_i != 5'd0);
    assign w_res_bad  = x_result_valid_i & ~(|w_res_oh) & ~w_res_ign;

    // Operand readiness: no pending writer, or the last pending writer retires this cycle
    always_comb begin
        w_rs_ok = '0;
        for (int i = 0; i < NUM_RS; i++) begin
            w_rs_ok[i] = (rs_addr_i[i*5 +: 5] == 5'd0)
                       | (r_pend[rs_addr_i[i*5 +: 5]] == '0)
                       | (w_res_dec & (x_result_rd_i == rs_addr_i[i*5 +: 5])
                          & (r_pend[rs_addr_i[i*5 +: 5]] == CNT_W'(1)));
        end
    end

    assign x_issue_req_rs_valid_o = w_rs_ok;
    assign w_dep     = (|(regs_used_i & ~w_rs_ok)) & ~x_illegal_insn_o;
    assign x_stall_o = w_dep | (instr_valid_i & x_illegal_insn_dec_i & w_full)
                     | (x_issue_valid_o & ~x_issue_ready_i);

    assign x_mem_ready_o    = ex_ready_i & (|w_mem_oh);
    assign x_mem_data_req_o = x_mem_valid_i & x_mem_ready_o;
    assign x_result_ready_o = 1'b1;
    assign x_outstanding_o  = w_occ;
    assign x_issue_req_id_o = r_id;
    assign x_prot_err_o     = r_prot_err;

`ifdef CV32E40P_X_DISP_KILL_EN
    localparam int SLOT_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    logic [4:0]               r_erd [MAX_OUTSTANDING];
    logic                     r_cmt_vld, r_cmt_alloc;
    logic [ID_WIDTH-1:0]      r_cmt_id;
    logic [SLOT_W-1:0]        r_cmt_slot, w_alloc_slot;
    logic [(1<<ID_WIDTH)-1:0] r_killed;
    logic                     w_kill;

    // Binary index of the slot being allocated, carried to the commit cycle
    always_comb begin
        w_alloc_slot = '0;
        for (int e = 0; e < MAX_OUTSTANDING; e++)
            if (w_free_oh[e]) w_alloc_slot = SLOT_W'(e);
    end

    assign w_kill = r_cmt_vld & flush_i;

    // Free the killed entry only if it still exists and no result is already freeing it
    always_comb begin
        w_kill_oh = '0;
        if (w_kill && r_cmt_alloc && r_vld[r_cmt_slot] && (r_eid[r_cmt_slot] == r_cmt_id)
            && !w_res_free[r_cmt_slot])
            w_kill_oh[r_cmt_slot] = 1'b1;
    end

    assign w_kill_dec       = (|w_kill_oh) & r_we[r_cmt_slot] & (r_erd[r_cmt_slot] != 5'd0);
    assign w_kill_rd        = r_erd[r_cmt_slot];
    assign w_res_ign        = r_killed[x_result_id_i];
    assign x_commit_valid_o = r_cmt_vld;
    assign x_commit_id_o    = r_cmt_id;
    assign x_commit_kill_o  = w_kill;

    // Registered commit stage, entry rd field and record of killed IDs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cmt_vld   <= 1'b0;
            r_cmt_alloc <= 1'b0;
            r_cmt_id    <= '0;
            r_cmt_slot  <= '0;
            r_killed    <= '0;
            for (int e = 0; e < MAX_OUTSTANDING; e++) r_erd[e] <= '0;
        end else begin
            r_cmt_vld   <= w_accept;
            r_cmt_alloc <= w_alloc;
            r_cmt_id    <= r_id;
            r_cmt_slot  <= w_alloc_slot;
            if (w_kill) r_killed[r_cmt_id] <= 1'b1;
            if (w_fire) r_killed[r_id] <= 1'b0;
            for (int e = 0; e < MAX_OUTSTANDING; e++)
                if (w_alloc_oh[e]) r_erd[e] <= waddr_id_i;
        end
    end
`else
    assign w_kill_oh        = '0;
    assign w_kill_dec       = 1'b0;
    assign w_kill_rd        = 5'd0;
    assign w_res_ign        = 1'b0;
    assign x_commit_valid_o = w_accept;
    assign x_commit_id_o    = r_id;
    assign x_commit_kill_o  = 1'b0;
`endif

    // Next pending count per register; simultaneous inc/dec cancel, underflow saturates at 0
    always_comb begin
        w_uflow = 1'b0;
        w_add   = '0;
        w_sub   = '0;
        for (int r = 0; r < 32; r++) begin
            w_pend_n[r] = r_pend[r];
            w_add = {1'b0, r_pend[r]} + (CNT_W+1)'(w_inc && (waddr_id_i == 5'(r)));
            w_sub = (CNT_W+1)'(w_res_dec && (x_result_rd_i == 5'(r)))
                  + (CNT_W+1)'(w_kill_dec && (w_kill_rd == 5'(r)));
            if (w_add < w_sub) begin
                w_uflow     = 1'b1;
                w_pend_n[r] = '0;
            end else begin
                w_pend_n[r] = CNT_W'(w_add - w_sub);
            end
        end
    end

    // Table, pending counters, ID counter, offload flag and sticky protocol error
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_vld      <= '0;
            r_we       <= '0;
            r_ls       <= '0;
            r_id       <= '0;
            r_off      <= 1'b0;
            r_prot_err <= 1'b0;
            for (int e = 0; e < MAX_OUTSTANDING; e++) r_eid[e] <= '0;
            for (int r = 0; r < 32; r++) r_pend[r] <= '0;
        end else begin
            r_vld <= (r_vld & ~w_res_free & ~w_kill_oh) | w_alloc_oh;
            r_we  <= (r_we & ~w_alloc_oh) | (w_alloc_oh & {MAX_OUTSTANDING{x_issue_resp_writeback_i}});
            r_ls  <= (r_ls & ~w_alloc_oh & ~(w_mem_oh & {MAX_OUTSTANDING{x_mem_data_req_o}}))
                   | (w_alloc_oh & {MAX_OUTSTANDING{x_issue_resp_loadstore_i}});
            if (w_fire) r_id <= r_id + ID_WIDTH'(1);
            r_off <= id_ready_i ? 1'b0 : (w_fire | r_off);
            if (w_res_bad || w_uflow) r_prot_err <= 1'b1;
            for (int e = 0; e < MAX_OUTSTANDING; e++)
                if (w_alloc_oh[e]) r_eid[e] <= r_id;
            for (int r = 0; r < 32; r++) r_pend[r] <= w_pend_n[r];
        end
    end

endmodule

// File: doc/cv32e40p_x_disp_mo.md
Name: cv32e40p_x_disp_mo

Overview:
- Parametrised multi-outstanding dispatcher between the ID stage and the CORE-V-XIF coprocessor interface.
- Keeps a table of up to MAX_OUTSTANDING offloaded instructions, indexed by ID.
- Tracks register hazards with per-register pending counters instead of a single-bit scoreboard.
- Counts outstanding offloaded load/stores per instruction ID. Sits in the ID stage beside the decoder; drives the issue, commit, result and mem handshakes.

Parameters:
- ID_WIDTH, 4: width of the XIF instruction ID; the ID counter wraps modulo 2^ID_WIDTH.
- NUM_RS, 3: number of source operands checked (2 or 3).
- MAX_OUTSTANDING, 4: in-flight table depth; must be >= 1 and <= 2^ID_WIDTH.
- CNT_W, $clog2(MAX_OUTSTANDING+1): width of the pending and occupancy counters.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- instr_valid_i  in  1  ID stage holds a valid instruction
- x_illegal_insn_dec_i  in  1  decoder flags the instruction as not core-native
- branch_or_jump_i  in  1  instruction is a branch or jump; suppresses offload
- id_ready_i  in  1  ID stage advances
- ex_ready_i  in  1  EX stage can accept a memory request
- waddr_id_i  in  5  rd of the ID instruction
- rs_addr_i  in  NUM_RS*5  source register addresses
- regs_used_i  in  NUM_RS  source operand is read
- x_issue_valid_o  out  1  issue request
- x_issue_ready_i  in  1  coprocessor accepts the handshake
- x_issue_resp_accept_i  in  1  coprocessor accepts the instruction
- x_issue_resp_writeback_i  in  1  instruction will write rd
- x_issue_resp_loadstore_i  in  1  instruction will issue a memory request
- x_issue_req_id_o  out  ID_WIDTH  current ID
- x_issue_req_rs_valid_o  out  NUM_RS  operand valid
- x_commit_valid_o  out  1  commit strobe
- x_commit_id_o  out  ID_WIDTH  commit ID
- x_commit_kill_o  out  1  kill flag
- x_result_valid_i  in  1  result strobe
- x_result_ready_o  out  1  tied 1
- x_result_id_i  in  ID_WIDTH  result ID
- x_result_rd_i  in  5  result destination register
- x_result_we_i  in  1  result writes rd
- x_mem_valid_i  in  1  coprocessor memory request
- x_mem_id_i  in  ID_WIDTH  memory request ID
- x_mem_ready_o  out  1  memory request accepted
- x_mem_data_req_o  out  1  memory request handshake completes
- x_stall_o  out  1  stall the ID stage
- x_illegal_insn_o  out  1  illegal-instruction pulse
- x_prot_err_o  out  1  sticky protocol error
- x_outstanding_o  out  CNT_W  table occupancy

Behaviour:
- Reset (sync, rst_i=1 at posedge) clears:
  - the table, pending counters, ID (0), offloaded flag, x_prot_err_o and the kill pipeline.
  - All outputs go to 0 except x_result_ready_o=1 and x_issue_req_rs_valid_o.
  - x_issue_req_rs_valid_o evaluates to all 1 once counters are cleared.
  - A reset mid-transaction silently drops all in-flight entries.
- fire = x_issue_valid_o & x_issue_ready_i.
- x_issue_valid_o = instr_valid_i & x_illegal_insn_dec_i & ~branch_or_jump_i & ~offloaded_q & ~full.
  - full = (occupancy == MAX_OUTSTANDING).
- x_issue_req_rs_valid_o[i] = (rs_addr_i[i]==0) | (pending[rs_addr_i[i]]==0) | (result freeing that register this cycle with pending==1).
- On fire, the ID increments (wraps), whether accepted or not.
  - ~accept: x_illegal_insn_o=1 in the same cycle (combinational); no entry is allocated.
- On fire & accept & (writeback | loadstore): allocate the lowest free entry {id, rd, we, ls}.
  - If writeback & rd!=0: pending[rd] += 1.
- offloaded_q: set on fire; cleared on id_ready_i, which has priority.
- Result (ready always 1): a matching valid entry is freed.
  - If we & rd!=0, pending[rd] -= 1.
  - An unmatched ID, or a counter underflow, sets x_prot_err_o (sticky); counters saturate at 0.
- Same-cycle increment and decrement of the same register leaves the counter unchanged.
- A same-cycle allocate and free keeps occupancy unchanged.
- x_mem_ready_o = ex_ready_i & a valid entry with id==x_mem_id_i and ls=1. Its ls bit clears on the handshake.
- x_mem_data_req_o = x_mem_valid_i & x_mem_ready_o.
- x_stall_o = dep | full_block | (x_issue_valid_o & ~x_issue_ready_i).
  - dep = any regs_used_i[i] with rs!=0 and pending!=0 not freed this cycle; masked when x_illegal_insn_o=1.
  - full_block = instr_valid_i & x_illegal_insn_dec_i & full.
- Commit (no macro): x_commit_valid_o = fire & accept, x_commit_id_o = x_issue_req_id_o, x_commit_kill_o = 0, all in the same cycle.

Optional Feature:
- CV32E40P_X_DISP_KILL_EN: adds input flush_i (1 bit; pipeline flush from the controller).
- With macro: commit is registered one cycle after fire & accept.
  - x_commit_kill_o = flush_i in that cycle.
  - A killed entry is freed in that cycle and its pending increment is undone.
  - A later result for a killed ID is ignored without raising x_prot_err_o.
- Without macro: no flush_i port; same-cycle commit; kill is 0.

Test Plan:
- Reset then single offload: fire with accept=1, wb=1, rd=5 → x_issue_req_id_o=0, commit same cycle, pending[5]=1, x_outstanding_o=1. Result with id 0, rd 5 → pending[5]=0, occupancy 0.
- Fill the table: 4 accepted writeback issues to rd 1..4 → fifth instruction sees x_issue_valid_o=0, x_stall_o=1. One result → issue resumes the next cycle.
- Reject: fire with accept=0 → x_illegal_insn_o pulses 1 cycle, ID advances to 1, x_outstanding_o unchanged.
- Hazard: rd=7 pending, next instruction reads rs1=7 → x_stall_o=1, rs_valid[0]=0. Result for rd 7 in the same cycle → rs_valid[0]=1, stall drops.
- Load/store: accept ls=1 with id 2, x_mem_valid_i with id 2 and ex_ready_i=1 → x_mem_data_req_o=1. A mem request with unknown id 9 → x_mem_ready_o=0.
- Protocol/wrap: 16 rejected issues → ID wraps to 0. Result with an unallocated ID → x_prot_err_o=1 until rst_i.
